hcordic_vector_engine: RTL and testbench
========================================

# hcordic_vector_engine

Iteration controller for the high-radix adaptive CORDIC in vectoring mode. It sits directly upstream of the vectoring LUT: it forms the 8-bit LUT address from the current Y residual and drives the LUT enable/done handshake. It consumes the returned kappa/theta/delta words to update X, Y, Z and the accumulated scale, and after N radix-16 iterations it emits the scaled magnitude and the angle.

## Interface
- N, default 4: number of radix-16 iterations; legal range 1..7.
- clock  in  1  rising-edge clock shared with the LUT.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- mode  in  2  01 = circular, 11 = hyperbolic; other values are illegal.
- x_in, y_in, z_in  in  32 each  signed Q2.30 operands.
- busy  out  1  high from the cycle after start is accepted until the cycle of valid.
- lut_enable  out  1  LUT read request.
- lut_operation  out  1  tied 0 (vectoring).
- lut_mode  out  2  mode latched at start.
- lut_address  out  8  LUT index.
- lut_done  in  1  LUT response strobe; registered, arrives one cycle after enable.
- lut_kappa, lut_theta, lut_delta  in  32 each  signed Q2.30 LUT words.
- x_out, z_out  out  32 each  signed Q2.30 results; held until the next accepted start.
- valid  out  1  one-cycle result strobe.
- error  out  1  one-cycle strobe for an illegal mode.

## Operation
- Reset drives every output to 0: busy, lut_enable, lut_address, lut_mode, x_out, z_out, valid, error. State returns to IDLE. Internal X, Y, Z, K and k are cleared. Reset mid-run aborts the run and produces no valid.
- FSM states: IDLE, ADDR, REQ, WAIT, UPDATE, SCALE, DONE.
- **IDLE, start=1, legal mode:**
  - Latch X=x_in, Y=y_in, Z=z_in, K=0x40000000 (1.0), k=0, and the mode.
  - Go to ADDR.
- **IDLE, start=1, illegal mode:** pulse error for one cycle and stay in IDLE. The LUT is never enabled.
- **ADDR:**
  - A = |Y| << 4k, computed 64 bits wide.
  - lut_address = 0xFF if any bit of A at or above bit 30 is set; otherwise lut_address = A[29:22].
  - sgn = Y[31].
  - Go to REQ.
- **REQ:** lut_enable=1 for exactly one cycle, then WAIT.
- **WAIT:** lut_enable=0. Stay until lut_done=1, then capture kappa, theta and delta and go to UPDATE. While enable is 0 the LUT only ever returns done=0, so no second response can occur.
- **UPDATE (d = ±delta, t = ±theta; negative when sgn=1):**
  - py = ((Y·d) >>> 30) >>> 4k
  - px = ((X·d) >>> 30) >>> 4k
  - Circular: X' = X + py. Hyperbolic: X' = X − py.
  - Y' = Y − px.
  - Z' = Z + (t >>> 4k).
  - K' = (K·kappa) >>> 30.
  - All products are 64-bit signed, truncated to 32 bits with wrap (no saturation).
  - Then k = k+1. Go to ADDR if k < N, else SCALE.
- **SCALE:** x_out = (X·K) >>> 30, z_out = Z. Go to DONE.
- **DONE:** valid=1, busy=0, return to IDLE.
- A start asserted while busy is ignored and is not queued.

## Timing
- Start is accepted at edge E0. busy rises after E0.
- Per iteration: ADDR 1 cycle, REQ 1, WAIT 1 (lut_done arrives at the edge after REQ), UPDATE 1. That is 4 cycles per iteration with a 1-cycle LUT.
- valid is high in the cycle after edge E0 + 4N + 1, i.e. 4N+2 cycles after acceptance. For N=4 that is 18 cycles.
- A new start is accepted in the cycle that follows valid at the earliest.
- A stalled lut_done stretches WAIT indefinitely. There is no timeout.
- lut_address and lut_mode are stable from ADDR through WAIT.

## Test plan
- **Reset mid-run:**
  - Start with circular mode, x_in=0x40000000, y_in=0x20000000.
  - Drop reset_n during WAIT of iteration 1.
  - Required: all outputs 0 immediately, no valid, and the next start runs normally.
- **Illegal mode:** start with mode=00. Required: error pulses once, lut_enable never rises, busy stays 0.
- **Zero Y, circular, N=4:**
  - Stimulus: x_in=0x40000000, y_in=0, z_in=0; the LUT model returns delta=0, theta=0, kappa=0x40000000 at address 0.
  - Required: every lut_address is 0x00, x_out=0x40000000, z_out=0, and valid 18 cycles after start.
- **Saturated address:** y_in=0x3FFFFFFF at k=1. Required: lut_address=0xFF.
- **Handshake stall:**
  - The LUT model delays done by 5 cycles on iteration 2.
  - Required: lut_enable is high for exactly one cycle per iteration, latency grows by 4, and the results are unchanged.
- **Hyperbolic vs reference model:**
  - 200 random Q2.30 operands with |y| < x, mode=11, bit-true C model of the UPDATE/SCALE equations.
  - Required: exact match on x_out and z_out; busy and valid protocol checked by assertions.

Source files
------------

// File: rtl/hcordic_vector_engine.sv
// rtl/hcordic_vector_engine.sv - vectoring-mode iteration controller for the radix-16 adaptive CORDIC
module hcordic_vector_engine #(
    parameter int N = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [31:0] x_in,
    input  logic [31:0] y_in,
    input  logic [31:0] z_in,
    output logic        busy,
    output logic        lut_enable,
    output logic        lut_operation,
    output logic [1:0]  lut_mode,
    output logic [7:0]  lut_address,
    input  logic        lut_done,
    input  logic [31:0] lut_kappa,
    input  logic [31:0] lut_theta,
    input  logic [31:0] lut_delta,
    output logic [31:0] x_out,
    output logic [31:0] z_out,
    output logic        valid,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_REQ, S_WAIT, S_UPDATE, S_SCALE, S_DONE
    } state_t;

    state_t state_q, state_d;

    logic signed [31:0] x_r, y_r, z_r, scale_r;
    logic signed [31:0] kappa_r, theta_r, delta_r;
    logic [2:0]         iter;
    logic               sgn;
    logic               mode_legal;
    logic               last_iter;
    logic [4:0]         sh;

    logic signed [31:0] d_sel, t_sel;
    logic signed [63:0] x_ext, y_ext, d_ext, k_ext, kappa_ext;
    logic signed [63:0] prod_yd, prod_xd, prod_kk, prod_xk;
    logic [63:0]        abs_y;
    logic signed [31:0] py, px;

    assign mode_legal = (mode == 2'b01) || (mode == 2'b11);
    assign last_iter  = ({1'b0, iter} + 4'd1) >= 4'(N);
    assign sh         = {iter, 2'b00};

    assign busy          = (state_q != S_IDLE) && (state_q != S_DONE);
    assign lut_enable    = (state_q == S_REQ);
    assign valid         = (state_q == S_DONE);
    assign lut_operation = 1'b0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start && mode_legal) state_d = S_ADDR;
            S_ADDR:   state_d = S_REQ;
            S_REQ:    state_d = S_WAIT;
            S_WAIT:   if (lut_done) state_d = S_UPDATE;
            S_UPDATE: state_d = last_iter ? S_SCALE : S_ADDR;
            S_SCALE:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Rotation direction follows the sign of Y captured when the address was formed.
    assign d_sel     = sgn ? -delta_r : delta_r;
    assign t_sel     = sgn ? -theta_r : theta_r;
    assign x_ext     = {{32{x_r[31]}}, x_r};
    assign y_ext     = {{32{y_r[31]}}, y_r};
    assign d_ext     = {{32{d_sel[31]}}, d_sel};
    assign k_ext     = {{32{scale_r[31]}}, scale_r};
    assign kappa_ext = {{32{kappa_r[31]}}, kappa_r};
    assign prod_yd   = y_ext * d_ext;
    assign prod_xd   = x_ext * d_ext;
    assign prod_kk   = k_ext * kappa_ext;
    assign prod_xk   = x_ext * k_ext;
    assign py        = 32'((prod_yd >>> 30) >>> sh);
    assign px        = 32'((prod_xd >>> 30) >>> sh);
    assign abs_y     = y_r[31] ? (~y_ext + 64'd1) : y_ext;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            x_r         <= '0;
            y_r         <= '0;
            z_r         <= '0;
            scale_r     <= '0;
            kappa_r     <= '0;
            theta_r     <= '0;
            delta_r     <= '0;
            iter        <= '0;
            sgn         <= 1'b0;
            lut_mode    <= '0;
            lut_address <= '0;
            x_out       <= '0;
            z_out       <= '0;
            error       <= 1'b0;
        end else begin
            error <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && mode_legal) begin
                        x_r      <= x_in;
                        y_r      <= y_in;
                        z_r      <= z_in;
                        scale_r  <= 32'h4000_0000;
                        iter     <= '0;
                        lut_mode <= mode;
                    end else if (start) begin
                        error <= 1'b1;
                    end
                end
                S_ADDR: begin
                    // Any magnitude at or above 1.0 after scaling saturates to the last LUT entry.
                    if (|((abs_y << sh) >> 30)) lut_address <= 8'hFF;
                    else                        lut_address <= 8'((abs_y << sh) >> 22);
                    sgn <= y_r[31];
                end
                S_WAIT: begin
                    if (lut_done) begin
                        kappa_r <= lut_kappa;
                        theta_r <= lut_theta;
                        delta_r <= lut_delta;
                    end
                end
                S_UPDATE: begin
                    x_r     <= lut_mode[1] ? (x_r - py) : (x_r + py);
                    y_r     <= y_r - px;
                    z_r     <= z_r + (t_sel >>> sh);
                    scale_r <= 32'(prod_kk >>> 30);
                    iter    <= iter + 3'd1;
                end
                S_SCALE: begin
                    x_out <= 32'(prod_xk >>> 30);
                    z_out <= z_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hcordic_vector_engine.sv
// tb/tb_hcordic_vector_engine.sv - scoreboard bench with LUT model and arithmetic reference
module tb_hcordic_vector_engine;

    localparam int NI = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  mode;
    logic [31:0] x_in, y_in, z_in;
    logic        busy, lut_enable, lut_operation;
    logic [1:0]  lut_mode;
    logic [7:0]  lut_address;
    logic        lut_done = 1'b0;
    logic [31:0] lut_kappa = '0, lut_theta = '0, lut_delta = '0;
    logic [31:0] x_out, z_out;
    logic        valid, error;

    always #5 clock = ~clock;

    hcordic_vector_engine #(.N(NI)) dut (
        .clock(clock), .reset_n(reset_n), .start(start), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .busy(busy), .lut_enable(lut_enable), .lut_operation(lut_operation),
        .lut_mode(lut_mode), .lut_address(lut_address), .lut_done(lut_done),
        .lut_kappa(lut_kappa), .lut_theta(lut_theta), .lut_delta(lut_delta),
        .x_out(x_out), .z_out(z_out), .valid(valid), .error(error)
    );

    typedef struct { logic [31:0] x; logic [31:0] z; int lat; } res_t;
    typedef struct { logic [7:0] addr; logic [1:0] md; } req_t;

    res_t        exp_q[$];
    req_t        req_q[$];
    logic [31:0] tbl_k[256], tbl_t[256], tbl_d[256];
    int          errors = 0, checks = 0;
    int          cyc = 0, start_cyc = 0, done_cnt = 0;
    int          stall_at = 0, stall_len = 1, en_cnt = 0;
    logic        prev_en = 1'b0;
    logic [7:0]  seen_addr[8];
    int          seen_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Registered LUT: done one edge after enable, optionally stretched on a chosen request.
    initial begin
        int cd;
        logic [7:0] al;
        cd = 0;
        al = '0;
        forever begin
            @(posedge clock);
            if (!reset_n) begin
                cd = 0;
                lut_done <= 1'b0;
            end else begin
                lut_done <= 1'b0;
                if (lut_enable) begin
                    en_cnt++;
                    al = lut_address;
                    cd = (en_cnt == stall_at) ? stall_len : 1;
                end
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        lut_done  <= 1'b1;
                        lut_kappa <= tbl_k[al];
                        lut_theta <= tbl_t[al];
                        lut_delta <= tbl_d[al];
                    end
                end
            end
        end
    end

    always @(negedge clock) begin
        req_t r;
        res_t e;
        if (lut_enable) begin
            check("enable_single_cycle", prev_en, 1'b0);
            check("busy_during_enable", busy, 1'b1);
            if (req_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_lut_enable actual=1 required=0");
            end else begin
                r = req_q.pop_front();
                check("lut_address", lut_address, r.addr);
                check("lut_mode", lut_mode, r.md);
            end
            if (seen_n < 8) seen_addr[seen_n] = lut_address;
            seen_n++;
        end
        prev_en = lut_enable;
        if (valid) begin
            check("busy_at_valid", busy, 1'b0);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_valid actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                check("x_out", x_out, e.x);
                check("z_out", z_out, e.z);
                check("latency", 32'(cyc - start_cyc), 32'(e.lat));
            end
            done_cnt++;
        end
    end

    task automatic model(input logic [31:0] xi, yi, zi, input logic [1:0] md, output res_t r);
        int X, Y, Z, K, d, t, py, px, dl, th, kp;
        longint a;
        logic [7:0] ad;
        X = xi; Y = yi; Z = zi; K = 32'h4000_0000;
        for (int k = 0; k < NI; k++) begin
            a = (Y < 0) ? -longint'(Y) : longint'(Y);
            a = a << (4 * k);
            ad = (a >= 64'sh4000_0000) ? 8'hFF : 8'(a >> 22);
            req_q.push_back('{ad, md});
            dl = tbl_d[ad]; th = tbl_t[ad]; kp = tbl_k[ad];
            d  = (Y < 0) ? -dl : dl;
            t  = (Y < 0) ? -th : th;
            py = int'((longint'(Y) * longint'(d)) >>> (30 + 4 * k));
            px = int'((longint'(X) * longint'(d)) >>> (30 + 4 * k));
            X  = (md == 2'b11) ? X - py : X + py;
            Y  = Y - px;
            Z  = Z + (t >>> (4 * k));
            K  = int'((longint'(K) * longint'(kp)) >>> 30);
        end
        r.x = int'((longint'(X) * longint'(K)) >>> 30);
        r.z = Z;
        r.lat = 4 * NI + 2;
    endtask

    task automatic run(input logic [31:0] xi, yi, zi, input logic [1:0] md,
                       input int s_at, input int s_len);
        res_t r;
        int d0;
        model(xi, yi, zi, md, r);
        if (s_at >= 1 && s_at <= NI) r.lat += s_len - 1;
        exp_q.push_back(r);
        @(negedge clock);
        stall_at = s_at; stall_len = s_len; en_cnt = 0; seen_n = 0;
        x_in = xi; y_in = yi; z_in = zi; mode = md; start = 1'b1;
        start_cyc = cyc;
        d0 = done_cnt;
        @(negedge clock);
        start = 1'b0;
        for (int i = 0; i < 200 && done_cnt == d0; i++) @(negedge clock);
        if (done_cnt == d0) begin
            checks++; errors++;
            $display("FAIL run_timeout actual=no_valid required=valid");
            exp_q.delete();
            req_q.delete();
        end
    endtask

    task automatic randomize_tables();
        for (int i = 0; i < 256; i++) begin
            tbl_k[i] = $urandom;
            tbl_t[i] = $urandom;
            tbl_d[i] = $urandom;
        end
    endtask

    initial begin
        logic [31:0] xs, ys, zs, m, sx, sz;
        reset_n = 1'b0; start = 1'b0; mode = 2'b00;
        x_in = '0; y_in = '0; z_in = '0;
        randomize_tables();
        repeat (3) @(negedge clock);
        check("rst_busy", busy, 1'b0);
        check("rst_lut_enable", lut_enable, 1'b0);
        check("rst_lut_address", lut_address, 8'h00);
        check("rst_lut_mode", lut_mode, 2'b00);
        check("rst_x_out", x_out, 32'h0);
        check("rst_z_out", z_out, 32'h0);
        check("rst_valid", valid, 1'b0);
        check("rst_error", error, 1'b0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);

        tbl_d[0] = 32'h0; tbl_t[0] = 32'h0; tbl_k[0] = 32'h4000_0000;
        run(32'h4000_0000, 32'h0, 32'h0, 2'b01, 0, 1);
        check("zero_y_x_out", x_out, 32'h4000_0000);
        check("zero_y_z_out", z_out, 32'h0);
        for (int i = 0; i < NI; i++) check("zero_y_address", seen_addr[i], 8'h00);

        tbl_d[8'hFF] = 32'h0;
        run(32'h4000_0000, 32'h3FFF_FFFF, 32'h0, 2'b01, 0, 1);
        check("saturated_address_k1", seen_addr[1], 8'hFF);

        xs = 32'h3000_0000; ys = 32'h1234_5678; zs = 32'h0100_0000;
        run(xs, ys, zs, 2'b01, 0, 1);
        sx = x_out; sz = z_out;
        run(xs, ys, zs, 2'b01, 2, 5);
        check("stall_x_unchanged", x_out, sx);
        check("stall_z_unchanged", z_out, sz);

        for (int j = 0; j < 2; j++) begin
            @(negedge clock);
            en_cnt = 0;
            mode = (j == 0) ? 2'b00 : 2'b10;
            start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            check("illegal_error_pulse", error, 1'b1);
            check("illegal_busy", busy, 1'b0);
            @(negedge clock);
            check("illegal_error_clears", error, 1'b0);
            repeat (4) @(negedge clock);
            check("illegal_busy_later", busy, 1'b0);
            check("illegal_no_enable", 32'(en_cnt), 32'h0);
        end

        begin
            res_t dummy;
            model(32'h4000_0000, 32'h2000_0000, 32'h0, 2'b01, dummy);
            @(negedge clock);
            x_in = 32'h4000_0000; y_in = 32'h2000_0000; z_in = '0;
            mode = 2'b01; stall_at = 0; en_cnt = 0; start = 1'b1;
            @(negedge clock);
            start = 1'b0;
            for (int i = 0; i < 20 && !lut_enable; i++) @(negedge clock);
            if (!lut_enable) begin
                checks++; errors++;
                $display("FAIL abort_enable_timeout actual=0 required=1");
            end
            @(negedge clock);
            check("abort_in_wait_busy", busy, 1'b1);
            #1 reset_n = 1'b0;
            #1;
            check("abort_busy", busy, 1'b0);
            check("abort_lut_enable", lut_enable, 1'b0);
            check("abort_lut_address", lut_address, 8'h00);
            check("abort_lut_mode", lut_mode, 2'b00);
            check("abort_x_out", x_out, 32'h0);
            check("abort_z_out", z_out, 32'h0);
            check("abort_valid", valid, 1'b0);
            check("abort_error", error, 1'b0);
            req_q.delete();
            repeat (3) @(negedge clock);
            reset_n = 1'b1;
            repeat (4) @(negedge clock);
            run(32'h4000_0000, 32'h2000_0000, 32'h0, 2'b01, 0, 1);
        end

        randomize_tables();
        for (int i = 0; i < 10; i++)
            run($urandom, $urandom, $urandom, 2'b01, 0, 1);

        for (int i = 0; i < 200; i++) begin
            xs = $urandom_range(32'h7FFF_FFFF, 32'h1);
            m  = $urandom % xs;
            ys = $urandom_range(1, 0) ? -m : m;
            zs = $urandom;
            run(xs, ys, zs, 2'b11, (i % 17 == 0) ? 3 : 0, 3);
        end

        repeat (3) @(negedge clock);
        if (exp_q.size() != 0 || req_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL leftover_expected actual=%0d required=0", exp_q.size() + req_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
